// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice (two half adders plus an OR)
// is reused over WIDTH cycles to form (a+b) mod 2**WIDTH and the carry out.
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg_a;
    logic [WIDTH-1:0] shreg_b;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic s1;
    logic c1;
    logic s;
    logic c2;
    logic cnext;
    logic last_bit;

    // Full-adder slice over the LSBs of the operand shift registers.
    assign s1       = shreg_a[0] ^ shreg_b[0];
    assign c1       = shreg_a[0] & shreg_b[0];
    assign s        = s1 ^ carry;
    assign c2       = s1 & carry;
    assign cnext    = c1 | c2;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_a <= '0;
            shreg_b <= '0;
            result  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg_a <= a;
                        shreg_b <= b;
                        carry   <= 1'b0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    shreg_a <= {1'b0, shreg_a[WIDTH-1:1]};
                    shreg_b <= {1'b0, shreg_b[WIDTH-1:1]};
                    result  <= {s, result[WIDTH-1:1]};
                    carry   <= cnext;
                    cnt     <= cnt + CNT_W'(1);
                    // The final sum bit is folded in directly, so the port sees only complete results.
                    if (last_bit) begin
                        sum  <= {s, result[WIDTH-1:1]};
                        cout <= cnext;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are registered copies of the state, one cycle behind it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state == RUN);
            done <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: an 8-bit instance for directed and random
// checks and a 16-bit instance running random operations concurrently.
module tb_serial_adder_ctrl;

    logic clk;
    int   total = 0;
    int   bad   = 0;

    logic       rst8, start8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic [8:0] q8[$];
    logic [8:0] e8;
    int         acc8 = 0;
    int         dn8  = 0;
    bit         fin8 = 0;

    logic        rst16, start16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;
    logic [16:0] q16[$];
    logic [16:0] e16;
    int          acc16 = 0;
    int          dn16  = 0;
    bit          fin16 = 0;

    serial_adder_ctrl #(.WIDTH(8), .CNT_W(5)) dut8 (
        .clk(clk), .rst_n(rst8), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(16), .CNT_W(5)) dut16 (
        .clk(clk), .rst_n(rst16), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done8) begin
            dn8++;
            chk("busy8_during_done", {63'd0, busy8}, 64'd0);
            if (q8.size() == 0) begin
                chk("done8_unexpected", 64'd1, 64'd0);
            end else begin
                e8 = q8.pop_front();
                chk("sum8", {55'd0, cout8, sum8}, {55'd0, e8});
            end
        end
        if (done16) begin
            dn16++;
            if (q16.size() == 0) begin
                chk("done16_unexpected", 64'd1, 64'd0);
            end else begin
                e16 = q16.pop_front();
                chk("sum16", {47'd0, cout16, sum16}, {47'd0, e16});
            end
        end
    end

    // Drive one 8-bit op at a negedge while the DUT is idle, then wait for done.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat, output int bc);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        q8.push_back({1'b0, a} + {1'b0, b});
        acc8++;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        lat = 1;
        bc = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bc++;
            @(negedge clk);
            lat++;
        end
        if (!done8) chk("op8_timeout", 64'(lat), 64'd10);
    endtask

    initial begin
        int lat, bc, dcnt;
        rst8 = 1'b0;
        start8 = 1'b0;
        a8 = '0;
        b8 = '0;
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
        chk("rst_busy", {63'd0, busy8}, 64'd0);
        chk("rst_done", {63'd0, done8}, 64'd0);
        chk("rst_sum", {55'd0, cout8, sum8}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_busy", {62'd0, busy8, done8}, 64'd0);
        end

        op8(8'h35, 8'h4A, lat, bc);
        chk("t2_latency", 64'(lat), 64'd10);
        chk("t2_busy_cycles", 64'(bc), 64'd8);
        chk("t2_sum", {55'd0, cout8, sum8}, 64'h07F);
        @(negedge clk);
        chk("t2_done_one_cycle", {63'd0, done8}, 64'd0);
        chk("t2_sum_held", {55'd0, cout8, sum8}, 64'h07F);

        op8(8'hFF, 8'h01, lat, bc);
        chk("t3_ff_01", {55'd0, cout8, sum8}, 64'h100);
        op8(8'hFF, 8'hFF, lat, bc);
        chk("t3_ff_ff", {55'd0, cout8, sum8}, 64'h1FE);
        op8(8'h00, 8'h00, lat, bc);
        chk("t3_00_00", {55'd0, cout8, sum8}, 64'h000);

        // start held high: accepted at P0 and again at P10 only.
        start8 = 1'b1;
        a8 = 8'h10;
        b8 = 8'h20;
        q8.push_back(9'h030);
        q8.push_back(9'h002);
        acc8 += 2;
        dcnt = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 3) begin
                a8 = 8'h01;
                b8 = 8'h01;
            end
            if (k == 12) start8 = 1'b0;
            if (done8) dcnt++;
            if (k == 10) chk("t4_first", {55'd0, cout8, sum8}, 64'h030);
            if (k == 20) chk("t4_second", {55'd0, cout8, sum8}, 64'h002);
        end
        chk("t4_done_count", 64'(dcnt), 64'd2);

        // Reset in the middle of a run discards the op.
        start8 = 1'b1;
        a8 = 8'hAA;
        b8 = 8'h55;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b0;
        @(negedge clk);
        rst8 = 1'b1;
        chk("t5_busy", {63'd0, busy8}, 64'd0);
        chk("t5_done", {63'd0, done8}, 64'd0);
        chk("t5_sum", {55'd0, cout8, sum8}, 64'd0);
        dcnt = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done8) dcnt++;
        end
        chk("t5_no_done", 64'(dcnt), 64'd0);
        op8(8'h0F, 8'h01, lat, bc);
        chk("t5_after", {55'd0, cout8, sum8}, 64'h010);

        for (int i = 0; i < 1000; i++) begin
            op8(8'($urandom), 8'($urandom), lat, bc);
        end
        fin8 = 1'b1;
    end

    initial begin
        logic [15:0] ra, rb;
        int lat;
        rst16 = 1'b0;
        start16 = 1'b0;
        a16 = '0;
        b16 = '0;
        repeat (2) @(negedge clk);
        rst16 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) begin
                ra = 16'hFFFF;
                rb = 16'h0001;
            end
            start16 = 1'b1;
            a16 = ra;
            b16 = rb;
            q16.push_back({1'b0, ra} + {1'b0, rb});
            acc16++;
            @(negedge clk);
            start16 = 1'b0;
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            lat = 1;
            while (!done16 && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            if (!done16 || i == 0) chk("op16_latency", 64'(lat), 64'd18);
        end
        fin16 = 1'b1;
    end

    initial begin
        wait (fin8 && fin16);
        repeat (3) @(negedge clk);
        chk("done8_count", 64'(dn8), 64'(acc8));
        chk("done16_count", 64'(dn16), 64'(acc16));
        chk("q8_empty", 64'(q8.size()), 64'd0);
        chk("q16_empty", 64'(q16.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
